// File: rtl/flag_if.sv
// Execute-stage flag bus: ALU result/carries and commit controls in,
// architectural flags, branch condition and overflow debug state out.
interface flag_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] result;
  logic             cin_msb;
  logic             cout_msb;
  logic             valid;
  logic             set_flags;
  logic             stall;
  logic             flush;
  logic [3:0]       cond;
  logic             cnt_clr;
  logic [3:0]       nzcv;
  logic             cond_true;
  logic             sticky_v;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output result, cin_msb, cout_msb, valid, set_flags, stall, flush, cond, cnt_clr,
    input  nzcv, cond_true, sticky_v, ovf_cnt
  );

  modport slave (
    input  result, cin_msb, cout_msb, valid, set_flags, stall, flush, cond, cnt_clr,
    output nzcv, cond_true, sticky_v, ovf_cnt
  );
endinterface

// File: rtl/flag_unit.sv
// NZCV flag register, B.cond evaluator and overflow debug counter.
// Define FLAG_BYPASS_EN to forward same-cycle committed flags into the condition check.
module flag_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic    clk,
  input  logic    reset,
  flag_if.slave   bus
);

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
    CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
    CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
    CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
  } cond_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  flags_t           raw;
  flags_t           eff;
  logic             upd;
  flags_t           nzcv_d,     nzcv_q;
  logic             sticky_v_d, sticky_v_q;
  logic [CNT_W-1:0] ovf_cnt_d,  ovf_cnt_q;
  logic             cond_true;

  always_comb begin
    raw.n = bus.result[WIDTH-1];
    raw.z = (bus.result == '0);
    raw.c = bus.cout_msb;
    raw.v = bus.cin_msb ^ bus.cout_msb;
    upd   = bus.valid & bus.set_flags & ~bus.stall & ~bus.flush;
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nzcv_d     = nzcv_q;
    sticky_v_d = sticky_v_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (upd) begin
      nzcv_d = raw;
    end
    // Clear wins over a same-cycle overflow, so that event is intentionally dropped.
    if (bus.cnt_clr) begin
      sticky_v_d = 1'b0;
      ovf_cnt_d  = '0;
    end else if (upd && raw.v) begin
      sticky_v_d = 1'b1;
      if (ovf_cnt_q != CNT_MAX) begin
        ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nzcv_q     <= '0;
      sticky_v_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      nzcv_q     <= nzcv_d;
      sticky_v_q <= sticky_v_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

`ifdef FLAG_BYPASS_EN
  // Forwarding lets a B.cond directly behind a flag-setting instruction resolve without a bubble.
  assign eff = upd ? raw : nzcv_q;
`else
  assign eff = nzcv_q;
`endif

  always_comb begin
    cond_true = 1'b1;
    unique case (cond_e'(bus.cond))
      CC_EQ: cond_true =  eff.z;
      CC_NE: cond_true = ~eff.z;
      CC_CS: cond_true =  eff.c;
      CC_CC: cond_true = ~eff.c;
      CC_MI: cond_true =  eff.n;
      CC_PL: cond_true = ~eff.n;
      CC_VS: cond_true =  eff.v;
      CC_VC: cond_true = ~eff.v;
      CC_HI: cond_true =  eff.c & ~eff.z;
      CC_LS: cond_true = ~eff.c |  eff.z;
      CC_GE: cond_true =  (eff.n == eff.v);
      CC_LT: cond_true =  (eff.n != eff.v);
      CC_GT: cond_true = ~eff.z & (eff.n == eff.v);
      CC_LE: cond_true =  eff.z | (eff.n != eff.v);
      CC_AL: cond_true = 1'b1;
      CC_NV: cond_true = 1'b1;
      default: cond_true = 1'b1;
    endcase
  end

  assign bus.nzcv      = nzcv_q;
  assign bus.sticky_v  = sticky_v_q;
  assign bus.ovf_cnt   = ovf_cnt_q;
  assign bus.cond_true = cond_true;

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit at WIDTH=64, CNT_W=2; expected values are hand-derived.
module tb_flag_unit;
  localparam int WIDTH = 64;
  localparam int CNT_W = 2;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  flag_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  flag_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] r,
                       input logic ci, input logic co);
    bus.valid     = v;
    bus.set_flags = s;
    bus.result    = r;
    bus.cin_msb   = ci;
    bus.cout_msb  = co;
  endtask

  task automatic cond_chk(input string tag, input logic [3:0] c, input logic exp);
    bus.cond = c;
    #1;
    check(tag, {7'd0, bus.cond_true}, {7'd0, exp});
  endtask

  initial begin
    reset       = 1'b0;
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.cond    = 4'b0001;
    drive(1'b1, 1'b1, {WIDTH{1'b1}}, 1'b1, 1'b0);
    tick();
    tick();
    check("rst_nzcv",   {4'd0, bus.nzcv}, 8'h00);
    check("rst_ovf",    {6'd0, bus.ovf_cnt}, 8'h00);
    check("rst_sticky", {7'd0, bus.sticky_v}, 8'h00);
    cond_chk("rst_ne", 4'b0001, 1'b1);
    cond_chk("rst_eq", 4'b0000, 1'b0);

    // Release reset while stalled: nothing may commit.
    bus.stall = 1'b1;
    #2 reset = 1'b1;
    tick();
    tick();
    check("stall_rel_nzcv", {4'd0, bus.nzcv}, 8'h00);
    check("stall_rel_ovf",  {6'd0, bus.ovf_cnt}, 8'h00);

    // Bypass: zero result with nzcv=0000, EQ evaluated in the commit cycle.
    bus.stall = 1'b0;
    drive(1'b1, 1'b1, '0, 1'b0, 1'b0);
`ifdef FLAG_BYPASS_EN
    cond_chk("bypass_same", 4'b0000, 1'b1);
`else
    cond_chk("bypass_same", 4'b0000, 1'b0);
`endif
    tick();
    check("zero_nzcv", {4'd0, bus.nzcv}, 8'h04);
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
    cond_chk("bypass_next", 4'b0000, 1'b1);

    // Negative result.
    drive(1'b1, 1'b1, MSB_ONLY, 1'b0, 1'b0);
    tick();
    check("neg_nzcv", {4'd0, bus.nzcv}, 8'h08);
    bus.valid = 1'b0;
    cond_chk("neg_lt", 4'b1011, 1'b1);
    cond_chk("neg_ge", 4'b1010, 1'b0);

    // Signed overflow.
    drive(1'b1, 1'b1, MSB_ONLY, 1'b1, 1'b0);
    tick();
    check("ovf_nzcv",   {4'd0, bus.nzcv}, 8'h09);
    check("ovf_sticky", {7'd0, bus.sticky_v}, 8'h01);
    check("ovf_cnt1",   {6'd0, bus.ovf_cnt}, 8'h01);
    bus.valid = 1'b0;
    cond_chk("ovf_ge", 4'b1010, 1'b1);
    cond_chk("ovf_vs", 4'b0110, 1'b1);
    cond_chk("ovf_gt", 4'b1100, 1'b1);

    // Carry without overflow.
    drive(1'b1, 1'b1, 64'd1, 1'b1, 1'b1);
    tick();
    check("carry_nzcv", {4'd0, bus.nzcv}, 8'h02);
    check("carry_cnt",  {6'd0, bus.ovf_cnt}, 8'h01);
    bus.valid = 1'b0;
    cond_chk("carry_hi", 4'b1000, 1'b1);
    cond_chk("carry_ls", 4'b1001, 1'b0);
    cond_chk("carry_al", 4'b1110, 1'b1);
    cond_chk("carry_nv", 4'b1111, 1'b1);

    // Suppression: stall, flush, valid=0, set_flags=0 must all block a V=1 update.
    drive(1'b1, 1'b1, '0, 1'b1, 1'b0);
    bus.stall = 1'b1;
    tick();
    check("sup_stall_nzcv", {4'd0, bus.nzcv}, 8'h02);
    check("sup_stall_cnt",  {6'd0, bus.ovf_cnt}, 8'h01);
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    tick();
    check("sup_flush_nzcv", {4'd0, bus.nzcv}, 8'h02);
    check("sup_flush_cnt",  {6'd0, bus.ovf_cnt}, 8'h01);
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    tick();
    check("sup_valid_nzcv", {4'd0, bus.nzcv}, 8'h02);
    check("sup_valid_cnt",  {6'd0, bus.ovf_cnt}, 8'h01);
    bus.valid     = 1'b1;
    bus.set_flags = 1'b0;
    tick();
    check("sup_sflag_nzcv", {4'd0, bus.nzcv}, 8'h02);

    // Saturation at 3 for CNT_W=2.
    drive(1'b1, 1'b1, MSB_ONLY, 1'b1, 1'b0);
    tick();
    check("sat_cnt2", {6'd0, bus.ovf_cnt}, 8'h02);
    tick();
    check("sat_cnt3", {6'd0, bus.ovf_cnt}, 8'h03);
    tick();
    check("sat_hold",   {6'd0, bus.ovf_cnt}, 8'h03);
    check("sat_sticky", {7'd0, bus.sticky_v}, 8'h01);

    // Clear together with a V=1 update: flags update, counter and sticky clear.
    drive(1'b1, 1'b1, '0, 1'b0, 1'b1);
    bus.cnt_clr = 1'b1;
    tick();
    check("clr_cnt",    {6'd0, bus.ovf_cnt}, 8'h00);
    check("clr_sticky", {7'd0, bus.sticky_v}, 8'h00);
    check("clr_nzcv",   {4'd0, bus.nzcv}, 8'h07);
    bus.cnt_clr = 1'b0;
    bus.valid   = 1'b0;
    cond_chk("clr_le", 4'b1101, 1'b1);
    cond_chk("clr_ne", 4'b0001, 1'b0);

    // Clear alone leaves flags untouched.
    bus.cnt_clr = 1'b1;
    tick();
    check("clr_only_nzcv", {4'd0, bus.nzcv}, 8'h07);
    bus.cnt_clr = 1'b0;

    // Asynchronous reset takes effect without a clock edge.
    #2 reset = 1'b0;
    #1;
    check("async_rst_nzcv", {4'd0, bus.nzcv}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
